// File: rtl/truth_table_checker.sv
// Self-checking stage for a 3-input function block. It realigns each stimulus
// vector with the block's delayed output, compares it against TRUTH_TABLE and
// reports a pass/fail verdict for one 8-sample sweep.
module truth_table_checker #(
  parameter logic [7:0] TRUTH_TABLE = 8'b01000011,
  parameter int         LATENCY     = 1,
  parameter int         CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             x_valid,
  input  logic [2:0]       x_in,
  input  logic             z_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int         DL_D       = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [1:0] DRAIN_LAST = 2'(DL_D - 1);

  state_t           state_q, state_d;
  logic [2:0]       acc_cnt_q, acc_cnt_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic [7:0]       cov_q, cov_d;
  logic [DL_D-1:0]  dl_vld_q, dl_vld_d;
  logic [2:0]       dl_x_q [DL_D];
  logic [2:0]       dl_x_d [DL_D];
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             fev_q, fev_d;
  logic [2:0]       fei_q, fei_d;

  logic             accept;
  logic             cmp_vld;
  logic [2:0]       cmp_x;
  logic             cmp_en;
  logic             mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept = (state_q == S_RUN) && x_valid;

  // Tap point of the realignment line; a zero-latency block is compared live.
  generate
    if (LATENCY == 0) begin : g_comb
      assign cmp_vld = accept;
      assign cmp_x   = x_in;
    end else begin : g_dly
      assign cmp_vld = dl_vld_q[DL_D-1];
      assign cmp_x   = dl_x_q[DL_D-1];
    end
  endgenerate

  assign cmp_en   = cmp_vld && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign mismatch = cmp_en && (z_in != TRUTH_TABLE[cmp_x]);

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cov_d       = cov_q;
    err_count_d = err_count_q;
    fev_d       = fev_q;
    fei_d       = fei_q;
    error_d     = mismatch;

    dl_vld_d[0] = accept;
    dl_x_d[0]   = x_in;
    for (int i = 1; i < DL_D; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_x_d[i]   = dl_x_q[i-1];
    end

    if (cmp_en) cov_d = cov_q | (8'b1 << cmp_x);
    if (mismatch) begin
      err_count_d = sat_inc(err_count_q);
      if (!fev_q) begin
        fev_d = 1'b1;
        fei_d = cmp_x;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          acc_cnt_d   = '0;
          drain_cnt_d = '0;
          cov_d       = '0;
          err_count_d = '0;
          fev_d       = 1'b0;
          fei_d       = '0;
          dl_vld_d    = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 3'd1;
          if (acc_cnt_q == 3'd7) begin
            state_d     = (LATENCY > 0) ? S_DRAIN : S_DONE;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
        else drain_cnt_d = drain_cnt_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next-state view so the verdict lands
    // in the same cycle the FSM enters DONE.
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_count_d == '0) && (cov_d == 8'hFF);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_cnt_q   <= '0;
      drain_cnt_q <= '0;
      cov_q       <= '0;
      dl_vld_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      fev_q       <= 1'b0;
      fei_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cov_q       <= cov_d;
      dl_vld_q    <= dl_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
      fev_q       <= fev_d;
      fei_q       <= fei_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DL_D; i++) dl_x_q[i] <= dl_x_d[i];
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error           = error_q;
  assign err_count       = err_count_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule
